decoder_seq: RTL and testbench
==============================

# decoder_seq

Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 3-to-8 combinational decoder. Adds three operating modes:
- **direct:** registered decode of `din`.
- **scan:** self-stepping one-hot sequencer with programmable dwell and scan limit, for row/digit strobing.
- **pulse:** one-shot timed strobe.

Sits between control logic and multiplexed loads (LED/7-segment digit selects, memory bank selects).

## Interface
- `SEL_W`, 3: select width; `OUT_W = 2**SEL_W` is derived, not overridable.
- `DWELL`, 4: cycles each index is held in scan mode; legal range ≥1.
- `PULSE_LEN`, 2: cycles `dout` is held active in pulse mode; legal range ≥1.
- `INVERT`, 0: 1 = active-low outputs (`dout` bitwise inverted, idle = all ones).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: enable; 0 blanks `dout` and freezes scan state.
- `mode` in 2: 00 DIRECT, 01 SCAN, 10 PULSE, 11 reserved.
- `din` in SEL_W: DIRECT/PULSE: index to decode. SCAN: last index of scan range.
- `start` in 1: PULSE trigger, sampled with `en`.
- `dout` out OUT_W: registered one-hot (or one-cold when `INVERT`=1).
- `idx` out SEL_W: index currently driven on `dout`.
- `wrap` out 1: one-cycle pulse when a scan wraps back to 0.
- `busy` out 1: high while a pulse is active.

## Operation
- **Reset:** `dout`=`{OUT_W{INVERT}}`, `idx`=0, `wrap`=0, `busy`=0, dwell/pulse counters=0, `mode_q`=00.
- **"Blank"** means `dout`=`{OUT_W{INVERT}}`. Active output means `onehot(idx) ^ {OUT_W{INVERT}}`.
- **DIRECT:**
  - `en`=1: `idx`<=`din`, `dout`<=active(`din`).
  - `en`=0: `dout` blank, `idx` holds.
- **SCAN:**
  - Dwell counter runs 0..DWELL-1 while `en`=1. At DWELL-1 it clears and `idx` advances.
  - Advance rule: if `idx` ≥ `din` then `idx`<=0 and `wrap`<=1; otherwise `idx`<=`idx`+1.
  - `din` lowered below the current `idx` therefore wraps at the next step; no out-of-range index is ever driven.
  - `din`=0 → `idx` stays 0 and `wrap` pulses every DWELL cycles.
  - `en`=0: counters freeze, `dout` blank, `wrap`=0. Re-enable resumes from the frozen state.
- **PULSE:** states IDLE and ACTIVE.
  - IDLE→ACTIVE: on `en`&`start`. Captures `din` into `idx`, `busy`<=1, `dout`<=active.
  - ACTIVE: holds for PULSE_LEN cycles, then returns to IDLE with `dout` blank and `busy`<=0.
  - `start` during ACTIVE is ignored; there is no retrigger.
  - `en`=0 during ACTIVE aborts: next cycle IDLE, blank, `busy`=0.
- **Reserved mode 11:** outputs blank, `busy`=0, all state held at clear values.
- **Mode change** (`mode` ≠ `mode_q`): that cycle clears `idx`, both counters and the PULSE FSM. `dout` is blank, `wrap`=0, `busy`=0. The new mode's behaviour starts the following cycle.
- **`rst` has priority** over every other input, including mid-pulse and mid-dwell.

## Timing
- All outputs are registered; no combinational input-to-output path.
- **DIRECT latency:** 1 cycle, `din`/`en` at edge k → `dout` valid after edge k.
- **SCAN:**
  - The first index is visible 1 cycle after `en` rises.
  - Each index is held exactly DWELL cycles.
  - Full period = (`din`+1)·DWELL cycles.
- **SCAN `wrap`:** asserted in the same cycle that `idx` first reads 0 after a wrap. Width is exactly 1 cycle, even when DWELL=1.
- **PULSE:** `dout` is active for exactly PULSE_LEN cycles, starting 1 cycle after the `start` edge. `busy` is coincident with `dout` being active.
- **Mode change:** 1 blank cycle, then the new behaviour; SCAN's first index follows the blank cycle.

## Structure
- **Package `decoder_pkg`:**
  - mode localparams `MODE_DIRECT`, `MODE_SCAN`, `MODE_PULSE`, `MODE_RSVD`;
  - PULSE FSM state enum (`P_IDLE`, `P_ACTIVE`);
  - function `onehot(sel, width)`.
- **Sub-module `decoder_dwell_timer`:** parametrised down-counter with load, enable and terminal-count outputs. Instantiated twice, once for the SCAN dwell and once for the PULSE length.
- The top level holds `mode_q`, `idx`, the PULSE FSM and the output register.

## Test plan
- **Reset/DIRECT:** SEL_W=3, `rst` for 2 cycles, then `en`=1, `din`=5 → `dout`=8'b0010_0000 one cycle later. `en`=0 → `dout`=0. With INVERT=1, reset value is 8'hFF.
- **SCAN basic:** DWELL=4, `din`=3 → `idx` sequence 0,1,2,3 with 4 cycles each, `wrap`=1 exactly on the first `idx`=0 after 3. Period is 16 cycles.
- **SCAN limit change:** at `idx`=6 with `din`=7, drop `din` to 2 → next step wraps to 0 with `wrap`=1. Indices 3..7 never appear afterwards.
- **SCAN freeze:** `en`=0 for 5 cycles mid-dwell → `dout` blank and `idx` held. On resume, the remaining dwell count completes.
- **PULSE:** PULSE_LEN=2, `din`=1, `start` → `dout`=8'h02 and `busy`=1 for exactly 2 cycles.
  - `start` again while busy: ignored.
  - `en`=0 during the pulse: aborts next cycle.
- **Mode switch/reset mid-operation:** SCAN→PULSE at `idx`=4 → 1 blank cycle, `idx`=0. `rst` asserted mid-pulse → all reset values the next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared mode encodings, pulse FSM states and the one-hot helper for decoder_seq.
package decoder_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_PULSE  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Widest decode the helper supports (SEL_W up to 8).
  localparam int unsigned MAX_OUT_W = 256;

  typedef enum logic {
    P_IDLE   = 1'b0,
    P_ACTIVE = 1'b1
  } pulse_state_t;

  // One-hot of sel; callers size-cast the result down to their own width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned sel, input int unsigned width);
    logic [MAX_OUT_W-1:0] result;
    result = '0;
    if ((sel < width) && (sel < MAX_OUT_W)) begin
      result[sel[7:0]] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// Reloading down-counter. Clear forces zero, load presets LOAD_VAL, enable steps
// the count (reloading from zero). o_tc flags an enabled step that lands on zero.
module decoder_dwell_timer #(
  parameter int LOAD_VAL = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;
  localparam logic [CW-1:0] LOAD_CNT = CW'(LOAD_VAL);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next;

  assign w_next = (r_count == '0) ? LOAD_CNT : (r_count - CW'(1));
  assign o_tc   = i_en && (w_next == '0);

  // Count register: clear beats load beats step; holds when idle.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_CNT;
    end else if (i_en) begin
      r_count <= w_next;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-2^N decoder with direct, self-stepping scan and one-shot pulse modes.
// In scan mode r_ptr runs one step ahead of the displayed index: the dwell timer
// decides when r_ptr moves, and the output register picks r_ptr up on the next
// enabled edge, which keeps every index on screen for exactly DWELL enabled cycles
// even across an enable freeze.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int DWELL     = 4,
  parameter int PULSE_LEN = 2,
  parameter int INVERT    = 0,
  localparam int OUT_W    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] din,
  input  logic             start,
  output logic [OUT_W-1:0] dout,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             busy
);

  localparam logic [OUT_W-1:0] BLANK = (INVERT != 0) ? '1 : '0;

  logic [1:0]       r_mode_q;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] r_ptr;
  logic [OUT_W-1:0] r_dout;
  logic             r_wrap;
  logic             r_wrap_pend;
  logic             r_busy;
  pulse_state_t     r_pstate;

  logic             w_mode_chg;
  logic             w_dwell_clr;
  logic             w_dwell_en;
  logic             w_dwell_tc;
  logic             w_pulse_clr;
  logic             w_pulse_load;
  logic             w_pulse_en;
  logic             w_pulse_tc;
  logic [OUT_W-1:0] w_act_din;
  logic [OUT_W-1:0] w_act_ptr;

  assign w_mode_chg = (mode != r_mode_q);
  assign w_act_din  = OUT_W'(onehot(32'(din), OUT_W)) ^ BLANK;
  assign w_act_ptr  = OUT_W'(onehot(32'(r_ptr), OUT_W)) ^ BLANK;

  // Dwell only counts in settled scan mode with enable high; frozen otherwise.
  assign w_dwell_clr = w_mode_chg || (r_mode_q != MODE_SCAN);
  assign w_dwell_en  = !w_dwell_clr && en;

  // Pulse length is loaded on trigger; losing enable or leaving pulse mode clears it.
  assign w_pulse_clr  = w_mode_chg || (r_mode_q != MODE_PULSE) || !en;
  assign w_pulse_load = !w_pulse_clr && (r_pstate == P_IDLE) && start;
  assign w_pulse_en   = !w_pulse_clr && (r_pstate == P_ACTIVE);

  decoder_dwell_timer #(
    .LOAD_VAL (DWELL - 1)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_dwell_clr),
    .i_load (1'b0),
    .i_en   (w_dwell_en),
    .o_tc   (w_dwell_tc)
  );

  decoder_dwell_timer #(
    .LOAD_VAL (PULSE_LEN)
  ) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_pulse_clr),
    .i_load (w_pulse_load),
    .i_en   (w_pulse_en),
    .o_tc   (w_pulse_tc)
  );

  // Mode tracking, scan pointer, pulse FSM and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst || w_mode_chg) begin
      r_mode_q    <= rst ? MODE_DIRECT : mode;
      r_idx       <= '0;
      r_ptr       <= '0;
      r_wrap_pend <= 1'b0;
      r_pstate    <= P_IDLE;
      r_dout      <= BLANK;
      r_wrap      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_mode_q)
        MODE_DIRECT: begin
          r_wrap <= 1'b0;
          r_busy <= 1'b0;
          if (en) begin
            r_idx  <= din;
            r_dout <= w_act_din;
          end else begin
            r_dout <= BLANK;
          end
        end
        MODE_SCAN: begin
          r_busy <= 1'b0;
          if (en) begin
            r_idx       <= r_ptr;
            r_dout      <= w_act_ptr;
            r_wrap      <= r_wrap_pend;
            r_wrap_pend <= w_dwell_tc && (r_ptr >= din);
            if (w_dwell_tc) begin
              r_ptr <= (r_ptr >= din) ? '0 : (r_ptr + SEL_W'(1));
            end
          end else begin
            r_dout <= BLANK;
            r_wrap <= 1'b0;
          end
        end
        MODE_PULSE: begin
          r_wrap <= 1'b0;
          if (r_pstate == P_IDLE) begin
            if (en && start) begin
              r_pstate <= P_ACTIVE;
              r_idx    <= din;
              r_dout   <= w_act_din;
              r_busy   <= 1'b1;
            end else begin
              r_dout <= BLANK;
              r_busy <= 1'b0;
            end
          end else if (!en || w_pulse_tc) begin
            r_pstate <= P_IDLE;
            r_dout   <= BLANK;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_idx       <= '0;
          r_ptr       <= '0;
          r_wrap_pend <= 1'b0;
          r_pstate    <= P_IDLE;
          r_dout      <= BLANK;
          r_wrap      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign dout = r_dout;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign busy = r_busy;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: an active-high instance and an active-low one
// share all inputs; each step is one clock edge followed by checks.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [2:0] din;
  logic       start;

  logic [7:0] dout;
  logic [2:0] idx;
  logic       wrap;
  logic       busy;
  logic [7:0] dout_inv;
  logic [2:0] idx_inv;
  logic       wrap_inv;
  logic       busy_inv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_seq #(
    .SEL_W (3), .DWELL (4), .PULSE_LEN (2), .INVERT (0)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .din (din), .start (start),
    .dout (dout), .idx (idx), .wrap (wrap), .busy (busy)
  );

  decoder_seq #(
    .SEL_W (3), .DWELL (4), .PULSE_LEN (2), .INVERT (1)
  ) dut_inv (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .din (din), .start (start),
    .dout (dout_inv), .idx (idx_inv), .wrap (wrap_inv), .busy (busy_inv)
  );

  function automatic logic [7:0] oh(input int k);
    logic [7:0] one;
    one = 8'd1;
    return one << k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b mode=%0d en=%0b din=%0d start=%0b -> dout=%02h idx=%0d wrap=%0b busy=%0b dout_inv=%02h",
             $time, rst, mode, en, din, start, dout, idx, wrap, busy, dout_inv);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; din = 3'd0; start = 1'b0;

    // Reset held for two cycles
    step(); step();
    chk("rst_dout", dout, 8'h00);
    chk("rst_idx", idx, 3'd0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout_inv", dout_inv, 8'hFF);
    rst = 1'b0;

    // DIRECT decode
    en = 1'b1; din = 3'd5; step();
    chk("direct5_dout", dout, 8'h20);
    chk("direct5_idx", idx, 3'd5);
    chk("direct5_dout_inv", dout_inv, 8'hDF);
    din = 3'd2; step();
    chk("direct2_dout", dout, 8'h04);
    en = 1'b0; step();
    chk("direct_off_dout", dout, 8'h00);
    chk("direct_off_idx", idx, 3'd2);
    chk("direct_off_dout_inv", dout_inv, 8'hFF);

    // SCAN basic: limit 3, dwell 4, 16-cycle period
    mode = 2'b01; din = 3'd3; step();
    chk("scan_chg_dout", dout, 8'h00);
    chk("scan_chg_idx", idx, 3'd0);
    en = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("scan_idx", idx, (c / 4) % 4);
      chk("scan_dout", dout, oh((c / 4) % 4));
      chk("scan_wrap", wrap, (c == 16));
    end

    // SCAN limit lowered while showing index 6
    mode = 2'b00; step();
    mode = 2'b01; din = 3'd7; step();
    chk("lim_chg_dout", dout, 8'h00);
    for (int c = 0; c < 25; c++) begin
      step();
      chk("lim_idx", idx, c / 4);
    end
    din = 3'd2;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("lim_hold6", idx, 3'd6);
    end
    for (int c = 0; c < 13; c++) begin
      step();
      chk("lim_idx_after", idx, (c / 4) % 3);
      chk("lim_wrap_after", wrap, ((c % 12) == 0));
    end

    // SCAN freeze mid-dwell (index 0 shown twice before freeze)
    step();
    chk("frz_pre_dout", dout, 8'h01);
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("frz_dout", dout, 8'h00);
      chk("frz_idx", idx, 3'd0);
      chk("frz_wrap", wrap, 1'b0);
    end
    en = 1'b1;
    step(); chk("frz_res1", dout, 8'h01);
    step(); chk("frz_res2", dout, 8'h01);
    step(); chk("frz_res3", dout, 8'h02);
    chk("frz_res3_idx", idx, 3'd1);

    // Mode switch SCAN -> PULSE while showing index 4
    mode = 2'b00; step();
    mode = 2'b01; din = 3'd7; step();
    for (int c = 0; c < 17; c++) step();
    chk("sw_idx4", idx, 3'd4);
    mode = 2'b10; step();
    chk("sw_dout", dout, 8'h00);
    chk("sw_idx", idx, 3'd0);
    chk("sw_busy", busy, 1'b0);
    chk("sw_wrap", wrap, 1'b0);

    // PULSE: two cycles active
    din = 3'd1; start = 1'b1; step();
    chk("p1_dout", dout, 8'h02);
    chk("p1_busy", busy, 1'b1);
    chk("p1_idx", idx, 3'd1);
    chk("p1_dout_inv", dout_inv, 8'hFD);
    start = 1'b0; step();
    chk("p2_dout", dout, 8'h02);
    chk("p2_busy", busy, 1'b1);
    step();
    chk("p3_dout", dout, 8'h00);
    chk("p3_busy", busy, 1'b0);
    step();
    chk("p4_dout", dout, 8'h00);

    // PULSE: start while active is ignored
    start = 1'b1; din = 3'd1; step();
    chk("rt1_dout", dout, 8'h02);
    din = 3'd3; step();
    chk("rt2_dout", dout, 8'h02);
    chk("rt2_idx", idx, 3'd1);
    start = 1'b0; step();
    chk("rt3_dout", dout, 8'h00);
    chk("rt3_busy", busy, 1'b0);

    // PULSE: enable dropped mid-pulse aborts
    start = 1'b1; din = 3'd1; step();
    chk("ab1_busy", busy, 1'b1);
    start = 1'b0; en = 1'b0; step();
    chk("ab2_dout", dout, 8'h00);
    chk("ab2_busy", busy, 1'b0);
    en = 1'b1; step();
    chk("ab3_dout", dout, 8'h00);
    chk("ab3_busy", busy, 1'b0);

    // Reset mid-pulse, then mode register restarts from DIRECT
    start = 1'b1; din = 3'd6; step();
    chk("rp1_dout", dout, 8'h40);
    start = 1'b0; rst = 1'b1; step();
    chk("rp2_dout", dout, 8'h00);
    chk("rp2_idx", idx, 3'd0);
    chk("rp2_busy", busy, 1'b0);
    chk("rp2_wrap", wrap, 1'b0);
    chk("rp2_dout_inv", dout_inv, 8'hFF);
    rst = 1'b0; start = 1'b1; din = 3'd2; step();
    chk("rp3_dout", dout, 8'h00);
    chk("rp3_busy", busy, 1'b0);
    step();
    chk("rp4_dout", dout, 8'h04);
    chk("rp4_busy", busy, 1'b1);
    start = 1'b0;

    // Reserved mode blanks everything
    mode = 2'b11; step();
    chk("rs1_dout", dout, 8'h00);
    chk("rs1_busy", busy, 1'b0);
    step();
    chk("rs2_dout", dout, 8'h00);
    chk("rs2_idx", idx, 3'd0);
    chk("rs2_busy", busy, 1'b0);
    chk("rs2_dout_inv", dout_inv, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
